// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single main-memory port between the instruction fetch unit (IFU)
// and the load/store unit (LSU). One transaction is in flight at a time:
//   IDLE -> BUSY (request presented to memory) -> RESP (ack to requester) -> IDLE
// A watchdog ends a BUSY phase that sees no mem_valid_in for TIMEOUT_CYCLES
// cycles. The requester then receives an error response with zero data.
//
// Parameters
//   ADDR_WIDTH      address width of all ports
//   DATA_WIDTH      read/write data width
//   TIMEOUT_CYCLES  max BUSY cycles without mem_valid_in; 0 disables watchdog
//
// Ports
//   clock_in        clock, rising edge
//   reset_in        synchronous reset, active low
//   halt_in         1 = grant no new IFU requests (LSU unaffected)
//   ifu_req_in      IFU read request, level, held until ifu_ack_out
//   ifu_addr_in     IFU read address
//   ifu_ack_out     1-cycle response pulse to IFU
//   ifu_rdata_out   IFU read data, valid with ifu_ack_out
//   ifu_err_out     IFU timeout flag, valid with ifu_ack_out
//   lsu_req_in      LSU request, level, held until lsu_ack_out
//   lsu_we_in       1 = write, 0 = read
//   lsu_addr_in     LSU address
//   lsu_wdata_in    LSU write data
//   lsu_ack_out     1-cycle response pulse to LSU
//   lsu_rdata_out   LSU read data (0 for writes), valid with lsu_ack_out
//   lsu_err_out     LSU timeout flag, valid with lsu_ack_out
//   mem_req_out     memory request, held until mem_valid_in or timeout
//   mem_we_out      memory write enable
//   mem_addr_out    memory address
//   mem_wdata_out   memory write data
//   mem_valid_in    memory completion strobe
//   mem_rdata_in    memory read data, sampled with mem_valid_in
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  halt_in,

    input  logic                  ifu_req_in,
    input  logic [ADDR_WIDTH-1:0] ifu_addr_in,
    output logic                  ifu_ack_out,
    output logic [DATA_WIDTH-1:0] ifu_rdata_out,
    output logic                  ifu_err_out,

    input  logic                  lsu_req_in,
    input  logic                  lsu_we_in,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_in,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_in,
    output logic                  lsu_ack_out,
    output logic [DATA_WIDTH-1:0] lsu_rdata_out,
    output logic                  lsu_err_out,

    output logic                  mem_req_out,
    output logic                  mem_we_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [DATA_WIDTH-1:0] mem_wdata_out,
    input  logic                  mem_valid_in,
    input  logic [DATA_WIDTH-1:0] mem_rdata_in
);

    // Counter only needs to reach TIMEOUT_CYCLES; keep one bit when disabled.
    localparam int unsigned CNT_W =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam bit WATCHDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    state_t                state_q,       state_d;
    owner_t                owner_q,       owner_d;
    owner_t                last_grant_q,  last_grant_d;
    logic [CNT_W-1:0]      cnt_q,         cnt_d;

    logic                  mem_req_q,     mem_req_d;
    logic                  mem_we_q,      mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,   mem_wdata_d;

    logic                  ifu_ack_q,     ifu_ack_d;
    logic [DATA_WIDTH-1:0] ifu_rdata_q,   ifu_rdata_d;
    logic                  ifu_err_q,     ifu_err_d;
    logic                  lsu_ack_q,     lsu_ack_d;
    logic [DATA_WIDTH-1:0] lsu_rdata_q,   lsu_rdata_d;
    logic                  lsu_err_q,     lsu_err_d;

    logic                  ifu_elig;
    logic                  lsu_elig;
    logic                  grant_ifu;
    logic [CNT_W-1:0]      cnt_next;
    logic                  timed_out;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  resp_fire;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        // Response outputs are non-zero only during the single RESP cycle,
        // so every other cycle simply clears them.
        ifu_ack_d    = 1'b0;
        ifu_rdata_d  = '0;
        ifu_err_d    = 1'b0;
        lsu_ack_d    = 1'b0;
        lsu_rdata_d  = '0;
        lsu_err_d    = 1'b0;

        ifu_elig     = ifu_req_in && !halt_in;
        lsu_elig     = lsu_req_in;
        // IFU wins when it is alone, or on a tie when LSU had the last grant.
        grant_ifu    = ifu_elig && (!lsu_elig || (last_grant_q == OWN_LSU));

        cnt_next     = cnt_q + CNT_W'(1);
        timed_out    = WATCHDOG_EN && (cnt_next == TIMEOUT_LIM);
        resp_rdata   = '0;
        resp_err     = 1'b0;
        resp_fire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ifu_elig || lsu_elig) begin
                    owner_d      = grant_ifu ? OWN_IFU : OWN_LSU;
                    last_grant_d = grant_ifu ? OWN_IFU : OWN_LSU;
                    mem_req_d    = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_BUSY;
                    if (grant_ifu) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = ifu_addr_in;
                        mem_wdata_d = '0;
                    end else begin
                        mem_we_d    = lsu_we_in;
                        mem_addr_d  = lsu_addr_in;
                        mem_wdata_d = lsu_wdata_in;
                    end
                end
            end

            ST_BUSY: begin
                if (WATCHDOG_EN) begin
                    cnt_d = cnt_next;
                end
                // Completion has priority over the watchdog on the same cycle.
                if (mem_valid_in) begin
                    resp_fire  = 1'b1;
                    resp_rdata = mem_we_q ? '0 : mem_rdata_in;
                    resp_err   = 1'b0;
                end else if (timed_out) begin
                    resp_fire  = 1'b1;
                    resp_rdata = '0;
                    resp_err   = 1'b1;
                end
                if (resp_fire) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                    if (owner_q == OWN_IFU) begin
                        ifu_ack_d   = 1'b1;
                        ifu_rdata_d = resp_rdata;
                        ifu_err_d   = resp_err;
                    end else begin
                        lsu_ack_d   = 1'b1;
                        lsu_rdata_d = resp_rdata;
                        lsu_err_d   = resp_err;
                    end
                end
            end

            ST_RESP: begin
                // Requests are deliberately ignored here so a requester that
                // keeps req high after its ack is only re-arbitrated in IDLE.
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                cnt_d     = '0;
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_LSU;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ifu_ack_q    <= 1'b0;
            ifu_rdata_q  <= '0;
            ifu_err_q    <= 1'b0;
            lsu_ack_q    <= 1'b0;
            lsu_rdata_q  <= '0;
            lsu_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ifu_ack_q    <= ifu_ack_d;
            ifu_rdata_q  <= ifu_rdata_d;
            ifu_err_q    <= ifu_err_d;
            lsu_ack_q    <= lsu_ack_d;
            lsu_rdata_q  <= lsu_rdata_d;
            lsu_err_q    <= lsu_err_d;
        end
    end

    assign mem_req_out   = mem_req_q;
    assign mem_we_out    = mem_we_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_wdata_out = mem_wdata_q;

    assign ifu_ack_out   = ifu_ack_q;
    assign ifu_rdata_out = ifu_rdata_q;
    assign ifu_err_out   = ifu_err_q;
    assign lsu_ack_out   = lsu_ack_q;
    assign lsu_rdata_out = lsu_rdata_q;
    assign lsu_err_out   = lsu_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Stimulus pushes the expected response
// of each transaction into a queue; a negedge monitor pops and compares it
// whenever an ack appears. Memory-side behaviour is checked inline.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clock_in = 1'b0;
    logic          reset_in;
    logic          halt_in;
    logic          ifu_req_in;
    logic [AW-1:0] ifu_addr_in;
    logic          ifu_ack_out;
    logic [DW-1:0] ifu_rdata_out;
    logic          ifu_err_out;
    logic          lsu_req_in;
    logic          lsu_we_in;
    logic [AW-1:0] lsu_addr_in;
    logic [DW-1:0] lsu_wdata_in;
    logic          lsu_ack_out;
    logic [DW-1:0] lsu_rdata_out;
    logic          lsu_err_out;
    logic          mem_req_out;
    logic          mem_we_out;
    logic [AW-1:0] mem_addr_out;
    logic [DW-1:0] mem_wdata_out;
    logic          mem_valid_in;
    logic [DW-1:0] mem_rdata_in;

    mem_port_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock_in     (clock_in),
        .reset_in     (reset_in),
        .halt_in      (halt_in),
        .ifu_req_in   (ifu_req_in),
        .ifu_addr_in  (ifu_addr_in),
        .ifu_ack_out  (ifu_ack_out),
        .ifu_rdata_out(ifu_rdata_out),
        .ifu_err_out  (ifu_err_out),
        .lsu_req_in   (lsu_req_in),
        .lsu_we_in    (lsu_we_in),
        .lsu_addr_in  (lsu_addr_in),
        .lsu_wdata_in (lsu_wdata_in),
        .lsu_ack_out  (lsu_ack_out),
        .lsu_rdata_out(lsu_rdata_out),
        .lsu_err_out  (lsu_err_out),
        .mem_req_out  (mem_req_out),
        .mem_we_out   (mem_we_out),
        .mem_addr_out (mem_addr_out),
        .mem_wdata_out(mem_wdata_out),
        .mem_valid_in (mem_valid_in),
        .mem_rdata_in (mem_rdata_in)
    );

    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_ifu;
        logic [31:0] rdata;
        bit          err;
        int          at;     // expected ack cycle, -1 = any
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    bit   mon_en       = 1'b0;
    bit   ifu_ack_prev = 1'b0;
    bit   lsu_ack_prev = 1'b0;

    // Response monitor
    always @(negedge clock_in) begin
        if (mon_en) begin
            if (ifu_ack_out || lsu_ack_out) begin
                chk("ack_single_pulse",
                    32'((ifu_ack_prev && ifu_ack_out) || (lsu_ack_prev && lsu_ack_out)), 32'd0);
                if (ifu_ack_out && lsu_ack_out) begin
                    chk("dual_ack", 32'd1, 32'd0);
                end else if (q.size() == 0) begin
                    chk("unexpected_ack", 32'({ifu_ack_out, lsu_ack_out}), 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("ack_owner_ifu", 32'(ifu_ack_out), 32'(mon_e.is_ifu));
                    if (mon_e.is_ifu) begin
                        chk("ifu_rdata", ifu_rdata_out, mon_e.rdata);
                        chk("ifu_err", 32'(ifu_err_out), 32'(mon_e.err));
                        chk("lsu_quiet", lsu_rdata_out | 32'(lsu_err_out), 32'd0);
                    end else begin
                        chk("lsu_rdata", lsu_rdata_out, mon_e.rdata);
                        chk("lsu_err", 32'(lsu_err_out), 32'(mon_e.err));
                        chk("ifu_quiet", ifu_rdata_out | 32'(ifu_err_out), 32'd0);
                    end
                    if (mon_e.at >= 0) chk("ack_cycle", 32'(cyc), 32'(mon_e.at));
                end
            end else begin
                chk("resp_outputs_idle",
                    ifu_rdata_out | lsu_rdata_out | 32'(ifu_err_out) | 32'(lsu_err_out), 32'd0);
            end
        end
        ifu_ack_prev = ifu_ack_out;
        lsu_ack_prev = lsu_ack_out;
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic wait_mem_req(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_req_out) ok = 1'b1;
            else tick();
        end
        chk({name, "_req_seen"}, 32'(mem_req_out), 32'd1);
    endtask

    // Wait for the grant, check the presented access, then complete it
    // `delay` cycles after the first BUSY cycle. Returns in the RESP cycle.
    task automatic serve(input string name, input logic [31:0] ea, input logic ewe,
                         input logic [31:0] ewd, input int delay, input logic [31:0] data);
        bit ok;
        wait_mem_req(name, ok);
        if (!ok) return;
        chk({name, "_addr"}, mem_addr_out, ea);
        chk({name, "_we"}, 32'(mem_we_out), 32'(ewe));
        chk({name, "_wdata"}, mem_wdata_out, ewd);
        repeat (delay) tick();
        chk({name, "_req_held"}, 32'(mem_req_out), 32'd1);
        chk({name, "_addr_held"}, mem_addr_out, ea);
        mem_valid_in = 1'b1;
        mem_rdata_in = data;
        tick();
        mem_valid_in = 1'b0;
        mem_rdata_in = '0;
        chk({name, "_req_dropped"}, 32'(mem_req_out), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_mem_req"}, 32'(mem_req_out), 32'd0);
        chk({name, "_mem_we"}, 32'(mem_we_out), 32'd0);
        chk({name, "_mem_addr"}, mem_addr_out, 32'd0);
        chk({name, "_mem_wdata"}, mem_wdata_out, 32'd0);
        chk({name, "_acks"}, 32'({ifu_ack_out, lsu_ack_out}), 32'd0);
        chk({name, "_rdata"}, ifu_rdata_out | lsu_rdata_out, 32'd0);
        chk({name, "_err"}, 32'({ifu_err_out, lsu_err_out}), 32'd0);
    endtask

    task automatic do_reset();
        reset_in = 1'b0;
        repeat (2) tick();
        reset_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x00000001 expected 0x00000000");
        $fatal(1, "bench timed out");
    end

    initial begin
        int t0;
        int n;
        bit ok;

        reset_in     = 1'b0;
        halt_in      = 1'b0;
        ifu_req_in   = 1'b0;
        ifu_addr_in  = '0;
        lsu_req_in   = 1'b0;
        lsu_we_in    = 1'b0;
        lsu_addr_in  = '0;
        lsu_wdata_in = '0;
        mem_valid_in = 1'b0;
        mem_rdata_in = '0;

        repeat (2) tick();
        check_all_zero("reset");
        mon_en   = 1'b1;
        reset_in = 1'b1;
        tick();

        // 1: IFU read, memory answers 2 cycles after the request appears
        t0          = cyc;
        ifu_addr_in = 32'h8;
        ifu_req_in  = 1'b1;
        q.push_back('{is_ifu: 1'b1, rdata: 32'hDEADBEEF, err: 1'b0, at: t0 + 4});
        tick();
        chk("t1_req_at_cycle1", 32'(mem_req_out), 32'd1);
        serve("t1", 32'h8, 1'b0, 32'h0, 2, 32'hDEADBEEF);
        ifu_req_in = 1'b0;
        tick();

        // 2: both requesters from reset, held -> IFU, LSU, IFU, LSU
        do_reset();
        ifu_addr_in = 32'h200;
        lsu_addr_in = 32'h300;
        lsu_we_in   = 1'b0;
        ifu_req_in  = 1'b1;
        lsu_req_in  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q.push_back('{is_ifu: (i % 2 == 0), rdata: 32'hA000_0000 + 32'(i), err: 1'b0, at: -1});
            serve("t2", (i % 2 == 0) ? 32'h200 : 32'h300, 1'b0, 32'h0, 1, 32'hA000_0000 + 32'(i));
        end
        ifu_req_in = 1'b0;
        lsu_req_in = 1'b0;
        repeat (2) tick();

        // 3: LSU write; memory returns junk data which must read back as 0
        lsu_we_in    = 1'b1;
        lsu_addr_in  = 32'h100;
        lsu_wdata_in = 32'h12345678;
        lsu_req_in   = 1'b1;
        q.push_back('{is_ifu: 1'b0, rdata: 32'h0, err: 1'b0, at: -1});
        serve("t3", 32'h100, 1'b1, 32'h12345678, 1, 32'hFFFF_FFFF);
        lsu_req_in   = 1'b0;
        lsu_we_in    = 1'b0;
        lsu_wdata_in = '0;
        tick();

        // valid on the same cycle the watchdog would fire: valid wins
        ifu_addr_in = 32'h40;
        ifu_req_in  = 1'b1;
        q.push_back('{is_ifu: 1'b1, rdata: 32'h55AA55AA, err: 1'b0, at: -1});
        serve("tboth", 32'h40, 1'b0, 32'h0, 3, 32'h55AA55AA);
        ifu_req_in = 1'b0;
        tick();

        // 4: watchdog with no memory response
        ifu_addr_in = 32'h44;
        ifu_req_in  = 1'b1;
        q.push_back('{is_ifu: 1'b1, rdata: 32'h0, err: 1'b1, at: -1});
        wait_mem_req("t4", ok);
        n = 0;
        while (mem_req_out && n < 20) begin
            n++;
            tick();
        end
        chk("t4_req_high_cycles", 32'(n), 32'(TO));
        ifu_req_in = 1'b0;
        tick();

        // 5: halt blocks IFU only; IFU granted right after release
        ifu_addr_in = 32'h500;
        lsu_addr_in = 32'h600;
        halt_in     = 1'b1;
        ifu_req_in  = 1'b1;
        lsu_req_in  = 1'b1;
        q.push_back('{is_ifu: 1'b0, rdata: 32'h0000600D, err: 1'b0, at: -1});
        serve("t5_lsu", 32'h600, 1'b0, 32'h0, 0, 32'h0000600D);
        lsu_req_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_halt_blocks_ifu", 32'(mem_req_out), 32'd0);
        end
        halt_in = 1'b0;
        tick();
        chk("t5_ifu_after_halt", 32'(mem_req_out), 32'd1);
        q.push_back('{is_ifu: 1'b1, rdata: 32'h000001F0, err: 1'b0, at: -1});
        serve("t5_ifu", 32'h500, 1'b0, 32'h0, 1, 32'h000001F0);
        ifu_req_in = 1'b0;
        tick();

        // 6: reset in BUSY, then a late valid must not produce an ack
        ifu_addr_in = 32'h700;
        ifu_req_in  = 1'b1;
        wait_mem_req("t6", ok);
        tick();
        reset_in   = 1'b0;
        ifu_req_in = 1'b0;
        tick();
        check_all_zero("t6_after_reset");
        reset_in = 1'b1;
        tick();
        mem_valid_in = 1'b1;
        mem_rdata_in = 32'h00000BAD;
        tick();
        mem_valid_in = 1'b0;
        mem_rdata_in = '0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_late_ack", 32'({ifu_ack_out, lsu_ack_out}), 32'd0);
            chk("t6_no_mem_req", 32'(mem_req_out), 32'd0);
            tick();
        end

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
